// File: rtl/i2c_master_arbiter_pkg.sv
// Shared types and constants for the I2C master arbiter.
// The optional abort timer is enabled with the I2C_ARB_TIMEOUT_EN macro.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  localparam logic       RD_OP     = 1'b1;
  localparam logic [7:0] RDATA_RST = 8'hff;

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Client-side bus of the I2C master arbiter: per-client requests in, shared completion out.
// The clients drive through the master modport, and the arbiter takes the slave modport.
interface i2c_master_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        cli_req;
  logic [NUM_REQ-1:0]        cli_rw;
  logic [NUM_REQ*DATA_W-1:0] cli_reg_addr;
  logic [NUM_REQ*DATA_W-1:0] cli_wdata;
  logic [NUM_REQ-1:0]        cli_ack;
  logic                      cli_err;
  logic [DATA_W-1:0]         cli_rdata;

  modport master (
    output cli_req, cli_rw, cli_reg_addr, cli_wdata,
    input  cli_ack, cli_err, cli_rdata
  );

  modport slave (
    input  cli_req, cli_rw, cli_reg_addr, cli_wdata,
    output cli_ack, cli_err, cli_rdata
  );
endinterface

// File: rtl/i2c_arb_rr_pick.sv
// Combinational round-robin picker: it returns the first requester after ptr, wrapping around.
// The search runs from the farthest candidate to the nearest, so the nearest requester is written last and wins.
module i2c_arb_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic               valid,
  output logic [2:0]         idx
);

  // priority search over all pointer offsets
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req[j] && (((int'(ptr) + i >= NUM_REQ) ? int'(ptr) + i - NUM_REQ
                                                    : int'(ptr) + i) == j)) begin
          valid = 1'b1;
          idx   = 3'(j);
        end else begin
          valid = valid;
        end
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one I2C EEPROM master between NUM_REQ clients.
// Optional I2C_ARB_TIMEOUT_EN aborts a transfer stuck in ISSUE after TIMEOUT_CYCLES cycles.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  i2c_master_arbiter_if.slave cli,
  output logic              m_wd_req,
  output logic              m_rd_req,
  input  logic              m_wr_ack,
  input  logic              m_rd_ack,
  output logic [DATA_W-1:0] m_wr_data,
  input  logic [DATA_W-1:0] m_rd_data,
  output logic [DATA_W-1:0] m_wr_reg_addr,
  output logic [DATA_W-1:0] m_rd_reg_addr,
  output logic              busy,
  output logic [2:0]        grant_id
);

  localparam logic [2:0] LAST_ID = 3'(NUM_REQ - 1);

  arb_state_e         state_r, state_nx;
  logic [2:0]         ptr_r, ptr_nx, grant_r, grant_nx;
  logic               wd_req_r, wd_req_nx, rd_req_r, rd_req_nx;
  logic               rw_r, rw_nx, busy_r;
  logic [DATA_W-1:0]  wdata_r, wdata_nx, addr_r, addr_nx, rdata_r, rdata_nx;
  logic [NUM_REQ-1:0] ack_r, ack_nx, grant_hot_s;
  logic               pick_valid_s, sel_rw_s, match_s;
  logic [2:0]         pick_idx_s;
  logic [DATA_W-1:0]  sel_addr_s, sel_wdata_s;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] cnt_r, cnt_nx;
  logic        err_r, err_nx;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  i2c_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (cli.cli_req),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // winner operand mux and one-hot of the current grant
  always_comb begin
    sel_rw_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    grant_hot_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx_s == 3'(i)) begin
        sel_rw_s    = cli.cli_rw[i];
        sel_addr_s  = cli.cli_reg_addr[i*DATA_W +: DATA_W];
        sel_wdata_s = cli.cli_wdata[i*DATA_W +: DATA_W];
      end else begin
        sel_rw_s    = sel_rw_s;
      end
      grant_hot_s[i] = (grant_r == 3'(i));
    end
    match_s = (rw_r == RD_OP) ? m_rd_ack : m_wr_ack;
  end

  // next-state and next-output logic
  always_comb begin
    state_nx  = state_r;
    ptr_nx    = ptr_r;
    grant_nx  = grant_r;
    wd_req_nx = wd_req_r;
    rd_req_nx = rd_req_r;
    rw_nx     = rw_r;
    wdata_nx  = wdata_r;
    addr_nx   = addr_r;
    rdata_nx  = rdata_r;
    ack_nx    = '0;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_nx    = cnt_r;
    err_nx    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_nx  = ISSUE;
          ptr_nx    = pick_idx_s;
          grant_nx  = pick_idx_s;
          rw_nx     = sel_rw_s;
          addr_nx   = sel_addr_s;
          wdata_nx  = sel_wdata_s;
          rd_req_nx = (sel_rw_s == RD_OP);
          wd_req_nx = (sel_rw_s != RD_OP);
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_nx    = 20'd0;
`endif
        end else begin
          state_nx  = IDLE;
        end
      end
      ISSUE: begin
        if (match_s) begin
          state_nx  = DONE;
          wd_req_nx = 1'b0;
          rd_req_nx = 1'b0;
          ack_nx    = grant_hot_s;
          rdata_nx  = (rw_r == RD_OP) ? m_rd_data : rdata_r;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_r == TIMEOUT_LAST) begin
          state_nx  = DONE;
          wd_req_nx = 1'b0;
          rd_req_nx = 1'b0;
          ack_nx    = grant_hot_s;
          err_nx    = 1'b1;
          rdata_nx  = DATA_W'(RDATA_RST);
        end else begin
          cnt_nx    = cnt_r + 20'd1;
        end
`else
        else begin
          state_nx  = ISSUE;
        end
`endif
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx  = IDLE;
        wd_req_nx = 1'b0;
        rd_req_nx = 1'b0;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      ptr_r    <= LAST_ID;
      grant_r  <= LAST_ID;
      wd_req_r <= 1'b0;
      rd_req_r <= 1'b0;
      rw_r     <= 1'b0;
      wdata_r  <= '0;
      addr_r   <= '0;
      rdata_r  <= DATA_W'(RDATA_RST);
      ack_r    <= '0;
      busy_r   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_r    <= 20'd0;
      err_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_nx;
      ptr_r    <= ptr_nx;
      grant_r  <= grant_nx;
      wd_req_r <= wd_req_nx;
      rd_req_r <= rd_req_nx;
      rw_r     <= rw_nx;
      wdata_r  <= wdata_nx;
      addr_r   <= addr_nx;
      rdata_r  <= rdata_nx;
      ack_r    <= ack_nx;
      busy_r   <= (state_nx != IDLE);
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_r    <= cnt_nx;
      err_r    <= err_nx;
`endif
    end
  end

  assign m_wd_req      = wd_req_r;
  assign m_rd_req      = rd_req_r;
  assign m_wr_data     = wdata_r;
  assign m_wr_reg_addr = addr_r;
  assign m_rd_reg_addr = addr_r;
  assign busy          = busy_r;
  assign grant_id      = grant_r;
  assign cli.cli_ack   = ack_r;
  assign cli.cli_rdata = rdata_r;
`ifdef I2C_ARB_TIMEOUT_EN
  assign cli.cli_err   = err_r;
`else
  assign cli.cli_err   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter: a table of single-client transfers plus
// directed sequences for wrong-type ack, idle ack, reset mid-transfer, round-robin and timeout.
module tb_i2c_master_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_wd_req, m_rd_req, busy;
  logic        m_wr_ack = 1'b0, m_rd_ack = 1'b0;
  logic [7:0]  m_wr_data, m_wr_reg_addr, m_rd_reg_addr;
  logic [7:0]  m_rd_data = 8'h00;
  logic [2:0]  grant_id;

  int checks = 0;
  int passed = 0;

  i2c_master_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) cli_bus ();

  i2c_master_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .cli           (cli_bus),
    .m_wd_req      (m_wd_req),
    .m_rd_req      (m_rd_req),
    .m_wr_ack      (m_wr_ack),
    .m_rd_ack      (m_rd_ack),
    .m_wr_data     (m_wr_data),
    .m_rd_data     (m_rd_data),
    .m_wr_reg_addr (m_wr_reg_addr),
    .m_rd_reg_addr (m_rd_reg_addr),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cli;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] mdata;
    logic [1:0] exp_ack;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cli(input int c, input logic req, input logic rw,
                         input logic [7:0] addr, input logic [7:0] wdata);
    cli_bus.cli_req[c]               = req;
    cli_bus.cli_rw[c]                = rw;
    cli_bus.cli_reg_addr[c*8 +: 8]   = addr;
    cli_bus.cli_wdata[c*8 +: 8]      = wdata;
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 8'h01, 8'h5a, 8'h99, 2'b01, 8'hff};
    vecs[1] = '{1, 1'b1, 8'h01, 8'h00, 8'h3c, 2'b10, 8'h3c};
    vecs[2] = '{0, 1'b1, 8'h7e, 8'h00, 8'ha5, 2'b01, 8'ha5};
    vecs[3] = '{1, 1'b0, 8'h10, 8'hc3, 8'h77, 2'b10, 8'ha5};
    vecs[4] = '{0, 1'b0, 8'hff, 8'h00, 8'h11, 2'b01, 8'ha5};
    vecs[5] = '{1, 1'b1, 8'h00, 8'h00, 8'h00, 2'b10, 8'h00};

    cli_bus.cli_req      = '0;
    cli_bus.cli_rw       = '0;
    cli_bus.cli_reg_addr = '0;
    cli_bus.cli_wdata    = '0;

    // reset values
    step();
    step();
    chk("rst_cli_ack", cli_bus.cli_ack, 2'b00);
    chk("rst_cli_err", cli_bus.cli_err, 1'b0);
    chk("rst_rdata", cli_bus.cli_rdata, 8'hff);
    chk("rst_wd_req", m_wd_req, 1'b0);
    chk("rst_rd_req", m_rd_req, 1'b0);
    chk("rst_wr_data", m_wr_data, 8'h00);
    chk("rst_wr_addr", m_wr_reg_addr, 8'h00);
    chk("rst_rd_addr", m_rd_reg_addr, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 3'd1);
    reset = 1'b0;
    step();

    // table: single-client transfers
    for (int v = 0; v < 6; v++) begin
      set_cli(vecs[v].cli, 1'b1, vecs[v].rw, vecs[v].addr, vecs[v].wdata);
      step();
      chk("vec_wd_req", m_wd_req, !vecs[v].rw);
      chk("vec_rd_req", m_rd_req, vecs[v].rw);
      chk("vec_wr_data", m_wr_data, vecs[v].wdata);
      chk("vec_wr_addr", m_wr_reg_addr, vecs[v].addr);
      chk("vec_rd_addr", m_rd_reg_addr, vecs[v].addr);
      chk("vec_grant", grant_id, 3'(vecs[v].cli));
      chk("vec_busy", busy, 1'b1);
      chk("vec_no_early_ack", cli_bus.cli_ack, 2'b00);
      set_cli(vecs[v].cli, 1'b1, vecs[v].rw, ~vecs[v].addr, ~vecs[v].wdata);
      step();
      chk("vec_hold_data", m_wr_data, vecs[v].wdata);
      chk("vec_hold_addr", m_rd_reg_addr, vecs[v].addr);
      m_rd_data = vecs[v].mdata;
      m_rd_ack  = vecs[v].rw;
      m_wr_ack  = !vecs[v].rw;
      step();
      m_rd_ack = 1'b0;
      m_wr_ack = 1'b0;
      chk("vec_ack", cli_bus.cli_ack, vecs[v].exp_ack);
      chk("vec_rdata", cli_bus.cli_rdata, vecs[v].exp_rdata);
      chk("vec_req_clear", {m_wd_req, m_rd_req}, 2'b00);
      chk("vec_err", cli_bus.cli_err, 1'b0);
      set_cli(vecs[v].cli, 1'b0, 1'b0, 8'h00, 8'h00);
      step();
      chk("vec_ack_once", cli_bus.cli_ack, 2'b00);
      chk("vec_idle", busy, 1'b0);
      chk("vec_rdata_hold", cli_bus.cli_rdata, vecs[v].exp_rdata);
    end

    // wrong-type ack is ignored during a read
    set_cli(0, 1'b1, 1'b1, 8'h22, 8'h00);
    step();
    m_wr_ack = 1'b1;
    step();
    m_wr_ack = 1'b0;
    chk("wrong_ack_rd_req", m_rd_req, 1'b1);
    chk("wrong_ack_no_ack", cli_bus.cli_ack, 2'b00);
    chk("wrong_ack_busy", busy, 1'b1);
    step();
    chk("wrong_ack_hold", m_rd_req, 1'b1);
    m_rd_ack  = 1'b1;
    m_rd_data = 8'h6b;
    step();
    m_rd_ack = 1'b0;
    chk("right_ack_ack", cli_bus.cli_ack, 2'b01);
    chk("right_ack_rdata", cli_bus.cli_rdata, 8'h6b);
    set_cli(0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();

    // master ack while idle is ignored
    m_rd_ack  = 1'b1;
    m_wr_ack  = 1'b1;
    m_rd_data = 8'h12;
    step();
    m_rd_ack = 1'b0;
    m_wr_ack = 1'b0;
    chk("idle_ack_busy", busy, 1'b0);
    chk("idle_ack_no_ack", cli_bus.cli_ack, 2'b00);
    chk("idle_ack_rdata", cli_bus.cli_rdata, 8'h6b);
    chk("idle_ack_no_req", {m_wd_req, m_rd_req}, 2'b00);

    // reset mid-ISSUE, with the pointer on client 0 beforehand
    set_cli(0, 1'b1, 1'b1, 8'h33, 8'h00);
    step();
    chk("mid_rst_grant0", grant_id, 3'd0);
    set_cli(1, 1'b1, 1'b0, 8'h44, 8'hd2);
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_rd_req", m_rd_req, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rdata", cli_bus.cli_rdata, 8'hff);
    chk("mid_rst_grant", grant_id, 3'd1);
    reset = 1'b0;

    // both clients request continuously: grants alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_grant", grant_id, 3'(k % 2));
      chk("rr_rd_req", m_rd_req, (k % 2) == 0);
      chk("rr_wd_req", m_wd_req, (k % 2) == 1);
      chk("rr_no_overlap", m_wd_req & m_rd_req, 1'b0);
      m_rd_data = 8'h80 + 8'(k);
      m_rd_ack  = (k % 2) == 0;
      m_wr_ack  = (k % 2) == 1;
      step();
      m_rd_ack = 1'b0;
      m_wr_ack = 1'b0;
      chk("rr_ack", cli_bus.cli_ack, (k % 2) == 0 ? 2'b01 : 2'b10);
      step();
      chk("rr_idle_busy", busy, 1'b0);
    end
    set_cli(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_cli(1, 1'b0, 1'b0, 8'h00, 8'h00);
    step();

`ifdef I2C_ARB_TIMEOUT_EN
    // no master ack: abort after 16 ISSUE cycles
    set_cli(0, 1'b1, 1'b0, 8'h05, 8'h66);
    step();
    chk("to_req_start", m_wd_req, 1'b1);
    repeat (15) step();
    chk("to_req_last", m_wd_req, 1'b1);
    chk("to_no_ack_yet", cli_bus.cli_ack, 2'b00);
    step();
    chk("to_req_drop", m_wd_req, 1'b0);
    chk("to_ack", cli_bus.cli_ack, 2'b01);
    chk("to_err", cli_bus.cli_err, 1'b1);
    chk("to_rdata", cli_bus.cli_rdata, 8'hff);
    set_cli(0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    chk("to_err_clear", cli_bus.cli_err, 1'b0);
    chk("to_idle", busy, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
